// File: rtl/rbt_s_idp_fix_deparser_if.sv
// rbt_s_idp_fix_deparser_if: valid/ready header bus with data, length and metadata.
// master drives valid/data/length/pkt_metadata, slave drives ready.
interface rbt_s_idp_fix_deparser_if #(
  parameter int HEADER_WIDTH       = 2048,
  parameter int PKT_METADATA_WIDTH = 272
);
  logic                          valid;
  logic                          ready;
  logic [HEADER_WIDTH-1:0]       data;
  logic [15:0]                   length;
  logic [PKT_METADATA_WIDTH-1:0] pkt_metadata;

  modport master (
    output valid, data, length, pkt_metadata,
    input  ready
  );

  modport slave (
    input  valid, data, length, pkt_metadata,
    output ready
  );
endinterface

// File: rtl/rbt_s_idp_fix_deparser.sv
// rbt_s_idp_fix_deparser: prepends a fixed IDP header to a transport header (TX path).
// Define IDP_DEPARSE_STATS_EN for saturating per-mode output counters.
module rbt_s_idp_fix_deparser #(
  parameter int HEADER_WIDTH       = 2048,
  parameter int PKT_METADATA_WIDTH = 272,
  parameter int IDP_HDR_BYTES      = 40
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [IDP_HDR_BYTES*8-1:0] cfg_idp_template,
  rbt_s_idp_fix_deparser_if.slave    in_proto_hdr,
  rbt_s_idp_fix_deparser_if.master   out_proto_hdr
`ifdef IDP_DEPARSE_STATS_EN
  ,
  output logic [31:0]                stat_emit_cnt,
  output logic [31:0]                stat_bypass_cnt,
  output logic [31:0]                stat_error_cnt
`endif
);
  localparam int HB     = IDP_HDR_BYTES * 8;
  localparam int TW     = HEADER_WIDTH - HB;
  localparam int T_IDP  = 45;
  localparam int T_SCMP = 51;
  localparam int T_SEAD = 52;
  localparam int T_SEAU = 53;
  localparam int T_SEAS = 54;
  localparam int T_V6   = 50;
  localparam int T_ERR  = 71;
  localparam int TL_OFS = 252;

  typedef enum logic [1:0] {
    M_BYPASS,
    M_EMIT,
    M_ERROR
  } mode_e;

  typedef struct packed {
    logic [HEADER_WIDTH-1:0]       data;
    logic [15:0]                   length;
    logic [PKT_METADATA_WIDTH-1:0] md;
  } hdr_t;

  typedef struct packed {
    hdr_t        h;
    mode_e       mode;
    logic [7:0]  nh;
    logic [HB-1:0] tmpl;
  } s1_t;

  logic [PKT_METADATA_WIDTH-1:0] imd;
  logic [2:0]  l4_cnt;
  logic [16:0] sum;
  logic [7:0]  nh_c;
  mode_e       mode_c;
  s1_t         s1_c;

  assign imd = in_proto_hdr.pkt_metadata;

  always_comb begin
    l4_cnt = 3'(imd[T_SCMP]) + 3'(imd[T_SEAD])
           + 3'(imd[T_SEAU]) + 3'(imd[T_SEAS]);
    sum  = 17'(in_proto_hdr.length) + 17'(IDP_HDR_BYTES);
    nh_c = 8'h00;
    if (l4_cnt == 3'd1) begin
      unique case (1'b1)
        imd[T_SCMP]: nh_c = 8'h00;
        imd[T_SEAD]: nh_c = 8'h01;
        imd[T_SEAU]: nh_c = 8'h02;
        imd[T_SEAS]: nh_c = 8'h03;
        default:     nh_c = 8'h00;
      endcase
    end
    if (!imd[T_IDP])
      mode_c = M_BYPASS;
    else if (l4_cnt != 3'd1 || sum > 17'(HEADER_WIDTH / 8))
      mode_c = M_ERROR;
    else
      mode_c = M_EMIT;
    s1_c.h.data   = in_proto_hdr.data;
    s1_c.h.length = in_proto_hdr.length;
    s1_c.h.md     = imd;
    s1_c.mode     = mode_c;
    s1_c.nh       = nh_c;
    s1_c.tmpl     = cfg_idp_template;
  end

  logic  s1_valid;
  logic  s2_valid;
  logic  s2_adv;
  logic  in_fire;
  s1_t   s1;
  hdr_t  s2;
  mode_e s2_mode;
  hdr_t  asm_c;
  logic [HB-1:0] hdr_c;

  // Header byte0[7:6] is the version field, always forced to zero
  always_comb begin
    asm_c = s1.h;
    hdr_c = s1.tmpl;
    hdr_c[HB-1 -: 2]  = 2'b00;
    hdr_c[HB-9 -: 8]  = s1.nh;
    hdr_c[HB-17 -: 8] = 8'(IDP_HDR_BYTES);
    unique case (s1.mode)
      M_EMIT: begin
        asm_c.data   = {hdr_c, s1.h.data[HEADER_WIDTH-1 -: TW]};
        asm_c.length = s1.h.length + 16'(IDP_HDR_BYTES);
        asm_c.md[T_V6] = 1'b1;
        asm_c.md[TL_OFS +: 9] = s1.h.md[TL_OFS +: 9] + 9'(IDP_HDR_BYTES);
      end
      M_ERROR: asm_c.md[T_ERR] = 1'b1;
      default: ;
    endcase
  end

  assign s2_adv             = !s2_valid || out_proto_hdr.ready;
  assign in_proto_hdr.ready = !s1_valid || s2_adv;
  assign in_fire            = in_proto_hdr.valid && in_proto_hdr.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s2_valid <= 1'b0;
      s2       <= '0;
      s2_mode  <= M_BYPASS;
    end else begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1       <= s1_c;
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2      <= asm_c;
          s2_mode <= s1.mode;
        end
      end
    end
  end

  assign out_proto_hdr.valid        = s2_valid;
  assign out_proto_hdr.data         = s2.data;
  assign out_proto_hdr.length       = s2.length;
  assign out_proto_hdr.pkt_metadata = s2.md;

`ifdef IDP_DEPARSE_STATS_EN
  logic out_fire;
  assign out_fire = s2_valid && out_proto_hdr.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_emit_cnt   <= '0;
      stat_bypass_cnt <= '0;
      stat_error_cnt  <= '0;
    end else if (out_fire) begin
      unique case (s2_mode)
        M_EMIT:
          if (stat_emit_cnt != '1) stat_emit_cnt <= stat_emit_cnt + 32'd1;
        M_ERROR:
          if (stat_error_cnt != '1) stat_error_cnt <= stat_error_cnt + 32'd1;
        default:
          if (stat_bypass_cnt != '1) stat_bypass_cnt <= stat_bypass_cnt + 32'd1;
      endcase
    end
  end
`endif
endmodule

// File: tb/tb_rbt_s_idp_fix_deparser.sv
// tb_rbt_s_idp_fix_deparser: vector table, directed corner sequences and
// randomized traffic against a byte-level reference model with a scoreboard.
module tb_rbt_s_idp_fix_deparser;
  localparam int HW = 2048;
  localparam int MW = 272;
  localparam int IB = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [IB*8-1:0] tmpl;

  always #5 clk = ~clk;

  rbt_s_idp_fix_deparser_if #(.HEADER_WIDTH(HW), .PKT_METADATA_WIDTH(MW)) in_if ();
  rbt_s_idp_fix_deparser_if #(.HEADER_WIDTH(HW), .PKT_METADATA_WIDTH(MW)) out_if ();

`ifdef IDP_DEPARSE_STATS_EN
  logic [31:0] st_emit, st_byp, st_err;
`endif

  rbt_s_idp_fix_deparser #(
    .HEADER_WIDTH(HW), .PKT_METADATA_WIDTH(MW), .IDP_HDR_BYTES(IB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_idp_template(tmpl),
    .in_proto_hdr(in_if.slave),
    .out_proto_hdr(out_if.master)
`ifdef IDP_DEPARSE_STATS_EN
    ,
    .stat_emit_cnt(st_emit),
    .stat_bypass_cnt(st_byp),
    .stat_error_cnt(st_err)
`endif
  );

  typedef struct {
    logic [HW-1:0] d;
    logic [15:0]   l;
    logic [MW-1:0] m;
  } pkt_t;

  typedef struct {
    bit         idp;
    bit [3:0]   l4;
    int         len;
    int         seatl;
    int         exp_len;
    bit         exp_err;
    bit         exp_emit;
    logic [7:0] exp_nh;
    int         exp_seatl;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  int   popped = 0;
  pkt_t sb[$];

  task automatic chk64(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic chk_md(input string n, input logic [MW-1:0] a, input logic [MW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask

  task automatic chk_data(input string n, input logic [HW-1:0] a, input logic [HW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      for (int b = 0; b < HW / 8; b++)
        if (a[HW-1-8*b -: 8] !== e[HW-1-8*b -: 8]) begin
          $display("FAIL %s byte%0d act=%02h exp=%02h", n, b,
                   a[HW-1-8*b -: 8], e[HW-1-8*b -: 8]);
          break;
        end
    end
  endtask

  function automatic logic [HW-1:0] rand_wide();
    logic [HW-1:0] r;
    for (int i = 0; i < HW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_md();
    logic [287:0] r;
    for (int i = 0; i < 9; i++) r[i*32 +: 32] = $urandom;
    return r[MW-1:0];
  endfunction

  function automatic logic [IB*8-1:0] rand_tmpl();
    logic [IB*8-1:0] r;
    for (int i = 0; i < IB / 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: output built byte by byte from the header rules
  function automatic pkt_t model(input logic [HW-1:0] d, input logic [15:0] len,
                                 input logic [MW-1:0] md, input logic [IB*8-1:0] t);
    pkt_t p;
    int n;
    logic [7:0] hb[IB];
    p.d = d;
    p.l = len;
    p.m = md;
    n = int'(md[51]) + int'(md[52]) + int'(md[53]) + int'(md[54]);
    if (!md[45]) return p;
    if (n != 1 || int'(len) + IB > HW / 8) begin
      p.m[71] = 1'b1;
      return p;
    end
    for (int b = 0; b < IB; b++) hb[b] = t[IB*8-1-8*b -: 8];
    hb[0][7:6] = 2'b00;
    hb[1] = md[51] ? 8'h00 : md[52] ? 8'h01 : md[53] ? 8'h02 : 8'h03;
    hb[2] = 8'(IB);
    for (int b = 0; b < HW / 8; b++)
      p.d[HW-1-8*b -: 8] = (b < IB) ? hb[b] : d[HW-1-8*(b-IB) -: 8];
    p.l = 16'(int'(len) + IB);
    p.m[50] = 1'b1;
    p.m[252 +: 9] = 9'((int'(md[252 +: 9]) + IB) % 512);
    return p;
  endfunction

  // One clock: inputs were set at the current negedge; evaluate the
  // handshakes that will fire at the next posedge, then move on.
  task automatic cyc(output bit acc);
    bit exp_rdy;
    pkt_t e;
    #1;
    exp_rdy = !(sb.size() == 2 && !out_if.ready);
    chk64("in_ready", 64'(in_if.ready), 64'(exp_rdy));
    if (out_if.valid) begin
      if (sb.size() == 0) begin
        chk64("sb_empty_on_valid", 64'(sb.size()), 64'd1);
      end else begin
        chk_data("out_data", out_if.data, sb[0].d);
        chk64("out_len", 64'(out_if.length), 64'(sb[0].l));
        chk_md("out_md", out_if.pkt_metadata, sb[0].m);
        if (out_if.ready) begin
          void'(sb.pop_front());
          popped++;
        end
      end
    end
    acc = in_if.valid && in_if.ready;
    if (acc) begin
      e = model(in_if.data, in_if.length, in_if.pkt_metadata, tmpl);
      sb.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    logic [HW-1:0] d;
    logic [MW-1:0] m;
    bit acc;
    d = rand_wide();
    m = rand_md();
    m[40 +: 32] = '0;
    m[45] = v.idp;
    m[51 +: 4] = v.l4;
    m[252 +: 9] = 9'(v.seatl);
    in_if.data = d;
    in_if.length = 16'(v.len);
    in_if.pkt_metadata = m;
    in_if.valid = 1'b1;
    out_if.ready = 1'b1;
    cyc(acc);
    chk64("vec_accept", 64'(acc), 64'd1);
    in_if.valid = 1'b0;
    chk64("lat1_valid", 64'(out_if.valid), 64'd0);
    cyc(acc);
    chk64("lat2_valid", 64'(out_if.valid), 64'd1);
    chk64("vec_len", 64'(out_if.length), 64'(v.exp_len));
    chk64("err_tag", 64'(out_if.pkt_metadata[71]), 64'(v.exp_err));
    chk64("idpv6_tag", 64'(out_if.pkt_metadata[50]), 64'(v.exp_emit));
    chk64("seatl", 64'(out_if.pkt_metadata[252 +: 9]), 64'(v.exp_seatl));
    if (v.exp_emit) begin
      chk64("byte0_ver", 64'(out_if.data[HW-1 -: 2]), 64'd0);
      chk64("byte1_nh", 64'(out_if.data[HW-9 -: 8]), 64'(v.exp_nh));
      chk64("byte2_len", 64'(out_if.data[HW-17 -: 8]), 64'h28);
      chk64("byte40", 64'(out_if.data[HW-1-8*IB -: 8]), 64'(d[HW-1 -: 8]));
    end else begin
      chk_data("nonemit_data", out_if.data, d);
    end
    cyc(acc);
  endtask

  task automatic gen_pkt();
    logic [MW-1:0] m;
    int r;
    m = rand_md();
    m[40 +: 32] = '0;
    m[45] = ($urandom % 4) != 0;
    r = $urandom % 8;
    if (r == 0) m[51 +: 4] = 4'(($urandom % 15) + 1);
    else m[51 + ($urandom % 4)] = 1'b1;
    in_if.data = rand_wide();
    in_if.length = ($urandom % 5 == 0) ? 16'($urandom_range(210, 230))
                                       : 16'($urandom_range(0, 200));
    in_if.pkt_metadata = m;
  endtask

  vec_t vt[10];

  initial begin
    bit acc;
    bit pend;
    bit tog;
    int sent;
    int guard;
    tmpl = rand_tmpl();
    in_if.valid = 1'b0;
    in_if.data = '0;
    in_if.length = '0;
    in_if.pkt_metadata = '0;
    out_if.ready = 1'b1;

    vt[0] = '{1'b1, 4'b0010, 20, 54, 60, 1'b0, 1'b1, 8'h01, 94};
    vt[1] = '{1'b0, 4'b0010, 100, 7, 100, 1'b0, 1'b0, 8'h00, 7};
    vt[2] = '{1'b1, 4'b0110, 30, 3, 30, 1'b1, 1'b0, 8'h00, 3};
    vt[3] = '{1'b1, 4'b0000, 30, 3, 30, 1'b1, 1'b0, 8'h00, 3};
    vt[4] = '{1'b1, 4'b0010, 220, 5, 220, 1'b1, 1'b0, 8'h00, 5};
    vt[5] = '{1'b1, 4'b0100, 216, 5, 256, 1'b0, 1'b1, 8'h02, 45};
    vt[6] = '{1'b1, 4'b0001, 8, 0, 48, 1'b0, 1'b1, 8'h00, 40};
    vt[7] = '{1'b1, 4'b1000, 0, 100, 40, 1'b0, 1'b1, 8'h03, 140};
    vt[8] = '{1'b1, 4'b0010, 10, 500, 50, 1'b0, 1'b1, 8'h01, 28};
    vt[9] = '{1'b1, 4'b0010, 217, 0, 217, 1'b1, 1'b0, 8'h00, 0};

    repeat (3) @(negedge clk);
    chk64("rst_out_valid", 64'(out_if.valid), 64'd0);
    chk64("rst_out_len", 64'(out_if.length), 64'd0);
    chk_md("rst_out_md", out_if.pkt_metadata, '0);
    chk64("rst_in_ready", 64'(in_if.ready), 64'd1);
`ifdef IDP_DEPARSE_STATS_EN
    chk64("rst_stat", 64'({st_emit, st_err}) | 64'(st_byp), 64'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_vec(vt[i]);

    // Eight back-to-back packets with out_ready toggling
    tog = 1'b1;
    sent = 0;
    popped = 0;
    guard = 0;
    while (sent < 8 && guard < 100) begin
      if (!in_if.valid) begin
        gen_pkt();
        in_if.valid = 1'b1;
      end
      out_if.ready = tog;
      tog = !tog;
      cyc(acc);
      if (acc) begin
        sent++;
        in_if.valid = 1'b0;
      end
      guard++;
    end
    in_if.valid = 1'b0;
    guard = 0;
    while (sb.size() != 0 && guard < 40) begin
      out_if.ready = tog;
      tog = !tog;
      cyc(acc);
      guard++;
    end
    chk64("b2b_sent", 64'(sent), 64'd8);
    chk64("b2b_popped", 64'(popped), 64'd8);
    chk64("b2b_drained", 64'(sb.size()), 64'd0);

    // Reset with two packets in flight
    out_if.ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      gen_pkt();
      in_if.valid = 1'b1;
      cyc(acc);
    end
    in_if.valid = 1'b0;
    chk64("pre_rst_valid", 64'(out_if.valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk64("midrst_valid", 64'(out_if.valid), 64'd0);
    chk64("midrst_len", 64'(out_if.length), 64'd0);
    chk64("midrst_ready", 64'(in_if.ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vt[0]);

    // Randomized traffic with template changes mid-flight
    pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pend) begin
        if ($urandom % 4 != 0) begin
          gen_pkt();
          in_if.valid = 1'b1;
          pend = 1'b1;
        end else begin
          in_if.valid = 1'b0;
        end
      end
      out_if.ready = ($urandom % 3) != 0;
      if (c % 37 == 36) tmpl = rand_tmpl();
      cyc(acc);
      if (acc) begin
        pend = 1'b0;
        in_if.valid = 1'b0;
      end
    end
    in_if.valid = 1'b0;
    out_if.ready = 1'b1;
    guard = 0;
    while (sb.size() != 0 && guard < 10) begin
      cyc(acc);
      guard++;
    end
    chk64("rand_drained", 64'(sb.size()), 64'd0);
    chk64("rand_idle_valid", 64'(out_if.valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
